// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues in-order requests to a variable-latency memory,
// buffers returned {addr,data} in a prefetch FIFO and presents the head to ID.
module if_prefetch_stage #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int PC_STEP    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branchAddr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]       DEPTH_V = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_out;
    logic [CW-1:0]     r_drop;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [ADDR_W-1:0] r_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] r_data_q [FIFO_DEPTH];

    logic [CW:0] w_occ;
    logic        w_credit_ok;
    logic        w_accept;
    logic        w_resp;
    logic        w_push;
    logic        w_valid;
    logic        w_pop;

    // Every accepted request reserves a FIFO slot, so a push can never overflow.
    assign w_occ       = {1'b0, r_cnt} + {1'b0, r_out};
    assign w_credit_ok = (w_occ < DEPTH_V);
    assign mem_req     = ~branch_taken & w_credit_ok;
    assign mem_addr    = r_fetch_pc;
    assign w_accept    = mem_req & mem_ready;
    assign w_resp      = mem_rvalid & (r_out != '0);
    assign w_push      = w_resp & (r_drop == '0) & ~branch_taken;
    assign w_valid     = (r_cnt != '0);
    assign w_pop       = w_valid & ~freeze & ~branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_cnt      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (branch_taken) begin
            // Everything still in flight belongs to the old path and is discarded on return.
            r_fetch_pc <= branchAddr;
            r_resp_pc  <= branchAddr;
            r_cnt      <= '0;
            r_out      <= r_out - CW'(w_resp);
            r_drop     <= r_out - CW'(w_resp);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + STEP_V;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + STEP_V;
                r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_out <= r_out + CW'(w_accept) - CW'(w_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr] <= r_resp_pc;
            r_data_q[r_wr_ptr] <= mem_rdata;
        end
    end

    always_comb begin
        valid       = w_valid;
        instruction = '0;
        pc          = '0;
        if (w_valid) begin
            instruction = r_data_q[r_rd_ptr];
            pc          = r_addr_q[r_rd_ptr] + STEP_V;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: in-order memory model with per-request latency,
// table-driven startup/freeze vectors, hand-written branch/reset sequences, random run.
module tb_if_prefetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branchAddr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    if_prefetch_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branchAddr(branchAddr), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .valid(valid), .instruction(instruction), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_due = 0;
    int lat_lo   = 1;
    int lat_hi   = 1;
    int consumed = 0;
    logic straggle = 1'b0;

    // Memory model: accepted requests waiting for their response cycle.
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Reference: next address ID should see, next address that should be requested.
    logic [31:0] exp_head;
    logic [31:0] exp_fetch;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    logic        r_frz, r_br, r_rdy, got;
    logic [31:0] r_tgt;

    typedef struct {
        logic        frz;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[20];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    task automatic check(input logic ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        freeze = 1'b0; branch_taken = 1'b0; branchAddr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        pend_addr.delete(); pend_due.delete();
        last_due = 0; straggle = 1'b0;
        exp_head = RESET_PC; exp_fetch = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, sample and check model, then pass the edge.
    task automatic step(input logic frz, input logic br, input logic [31:0] tgt, input logic rdy);
        int d;
        @(negedge clk);
        freeze = frz; branch_taken = br; branchAddr = tgt; mem_ready = rdy;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else if (straggle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            straggle   = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #1;
        s_req = mem_req; s_addr = mem_addr; s_valid = valid; s_instr = instruction; s_pc = pc;
        if (br) check(s_req == 1'b0, "req_in_branch", 32'(s_req), 32'h0);
        if (s_req && rdy) begin
            check(s_addr == exp_fetch, "fetch_addr", s_addr, exp_fetch);
            d = cyc + int'($urandom_range(lat_lo, lat_hi));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_addr.push_back(s_addr);
            pend_due.push_back(d);
            exp_fetch = exp_fetch + 32'd4;
            check(pend_addr.size() <= 4, "outstanding_le_depth", 32'(pend_addr.size()), 32'd4);
        end
        if (s_valid) begin
            check(s_pc == exp_head + 32'd4, "head_pc", s_pc, exp_head + 32'd4);
            check(s_instr == word(exp_head), "head_instr", s_instr, word(exp_head));
            if (!frz && !br) begin
                exp_head = exp_head + 32'd4;
                consumed++;
            end
        end else begin
            check(s_instr == 32'h0 && s_pc == 32'h0, "idle_zero", s_instr | s_pc, 32'h0);
        end
        if (br) begin
            exp_head  = tgt;
            exp_fetch = tgt;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        // {freeze, exp_req, exp_addr, exp_valid, exp_pc}; latency 1, ready always high.
        tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4};
        tbl[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd8};
        tbl[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tbl[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
        tbl[6]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[8]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[9]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[10] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[11] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[12] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[13] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[14] = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd12};
        tbl[15] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
        tbl[16] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};
        tbl[17] = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd24};
        tbl[18] = '{1'b0, 1'b1, 32'd36, 1'b1, 32'd28};
        tbl[19] = '{1'b0, 1'b1, 32'd40, 1'b1, 32'd32};

        // Startup latency and freeze/credit exhaustion.
        do_reset();
        check(valid == 1'b0 && instruction == 32'h0 && pc == 32'h0, "reset_outputs",
              {31'h0, valid} | instruction | pc, 32'h0);
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].frz, 1'b0, 32'h0, 1'b1);
            check(s_req == tbl[i].exp_req, "t_req", 32'(s_req), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) check(s_addr == tbl[i].exp_addr, "t_addr", s_addr, tbl[i].exp_addr);
            check(s_valid == tbl[i].exp_valid, "t_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            check(s_pc == (tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0), "t_pc", s_pc,
                  tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
            check(s_instr == (tbl[i].exp_valid ? word(tbl[i].exp_pc - 32'd4) : 32'h0), "t_instr",
                  s_instr, tbl[i].exp_valid ? word(tbl[i].exp_pc - 32'd4) : 32'h0);
        end

        // Branch with two requests in flight at latency 3.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            got = s_valid;
        end
        check(got, "branch_first_valid_seen", 32'(got), 32'h1);
        check(s_pc == 32'h44, "branch_first_pc", s_pc, 32'h44);
        check(s_instr == word(32'h40), "branch_first_instr", s_instr, word(32'h40));

        // Branch coinciding with a response while frozen.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                step(1'b1, 1'b1, 32'h80, 1'b1);
                got = 1'b1;
            end else begin
                step(1'b1, 1'b0, 32'h0, 1'b1);
            end
        end
        check(got, "branch_rvalid_aligned", 32'(got), 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check(s_valid == 1'b0, "branch_rvalid_empty", 32'(s_valid), 32'h0);
        check(s_req == 1'b1 && s_addr == 32'h80, "branch_rvalid_fetch", s_addr, 32'h80);

        // Asynchronous reset between edges, then a post-reset straggler response.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check(valid == 1'b1, "pre_reset_valid", 32'(valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check(valid == 1'b0 && instruction == 32'h0 && pc == 32'h0, "async_reset_outputs",
              {31'h0, valid} | instruction | pc, 32'h0);
        check(mem_addr == RESET_PC, "async_reset_fetch", mem_addr, RESET_PC);
        do_reset();
        straggle = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check(s_req == 1'b1 && s_addr == RESET_PC, "first_req_after_reset", s_addr, RESET_PC);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random ready, latency, freeze and occasional redirects.
        do_reset();
        lat_lo = 1; lat_hi = 4;
        consumed = 0;
        for (int g = 0; g < 20000 && consumed < 500; g++) begin
            r_frz = ($urandom_range(0, 99) < 30);
            r_br  = ($urandom_range(0, 99) < 3);
            r_tgt = 32'($urandom_range(0, 1023)) << 2;
            r_rdy = ($urandom_range(0, 3) != 0);
            step(r_frz, r_br, r_tgt, r_rdy);
        end
        check(consumed >= 500, "random_progress", 32'(consumed), 32'd500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
